// File: rtl/apb_reg_pkg.sv
// apb_reg_pkg: shared types and constants for the APB register bridge.
//   state_t    - bridge FSM states
//   WR_LATENCY - APB access cycles for a write or an error, PREADY cycle included
//   RD_LATENCY - APB access cycles for a read, PREADY cycle included
package apb_reg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    RESP
  } state_t;

  localparam int unsigned WR_LATENCY = 2;
  localparam int unsigned RD_LATENCY = 3;

endpackage

// File: rtl/apb_reg_bridge.sv
// apb_reg_bridge: APB slave front-end for the general-purpose register bank.
// It turns each APB transfer into a single-cycle read_flag/write_flag strobe.
// The address and write data are held on amba_addr/data_in for the registers.
// Reads add one wait state to cover the bank's registered read latency.
// Out-of-range addresses get a PSLVERR response and produce no strobe.
//   SYS_CLK, rst        - clock (rising edge), synchronous active-high reset
//   PSEL..PWDATA        - APB request inputs
//   PRDATA/PREADY/PSLVERR - APB response (registered)
//   reg_rdata           - OR-combined data_out of the register bank
//   amba_addr, data_in  - address / write data broadcast to the registers
//   read_flag, write_flag - one-cycle strobes to the registers
module apb_reg_bridge
  import apb_reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                  SYS_CLK,
  input  logic                  rst,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  output logic [DATA_WIDTH-1:0] amba_addr,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  read_flag,
  output logic                  write_flag
);

  state_t state;
  logic   dir;   // latched PWRITE
  logic   err;   // latched out-of-range flag

  always_ff @(posedge SYS_CLK) begin
    if (rst) begin
      state      <= IDLE;
      dir        <= 1'b0;
      err        <= 1'b0;
      PRDATA     <= '0;
      PREADY     <= 1'b0;
      PSLVERR    <= 1'b0;
      amba_addr  <= '0;
      data_in    <= '0;
      read_flag  <= 1'b0;
      write_flag <= 1'b0;
    end else begin
      // Strobes are pulses: they are asserted only on the edge leaving ISSUE.
      read_flag  <= 1'b0;
      write_flag <= 1'b0;
      case (state)
        IDLE: begin
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          PRDATA  <= '0;
          if (PSEL && !PENABLE) begin
            amba_addr <= PADDR;
            data_in   <= PWDATA;
            dir       <= PWRITE;
            // Widened compare so NUM_REGS == 2**DATA_WIDTH stays correct.
            err       <= (32'(PADDR) >= NUM_REGS);
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!PSEL) begin
            state <= IDLE;
          end else if (PENABLE) begin
            if (err) begin
              PREADY  <= 1'b1;
              PSLVERR <= 1'b1;
              PRDATA  <= '0;
              state   <= RESP;
            end else if (dir) begin
              write_flag <= 1'b1;
              PREADY     <= 1'b1;
              PRDATA     <= '0;
              state      <= RESP;
            end else begin
              read_flag <= 1'b1;
              state     <= WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          if (!PSEL) begin
            state <= IDLE;
          end else begin
            PRDATA  <= reg_rdata;
            PREADY  <= 1'b1;
            PSLVERR <= 1'b0;
            state   <= RESP;
          end
        end
        RESP: begin
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          PRDATA  <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_reg_bridge.sv
// tb_apb_reg_bridge: self-checking bench for apb_reg_bridge.
// A behavioural register bank answers the bridge's strobes. Expected
// responses come from a fixed vector table and from a transaction-level
// model of the register contents.
module tb_apb_reg_bridge;
  import apb_reg_pkg::*;

  localparam int unsigned NR = 16;

  logic       SYS_CLK = 1'b0;
  logic       rst;
  logic       PSEL, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA, PRDATA;
  logic       PREADY, PSLVERR;
  logic [7:0] reg_rdata;
  logic [7:0] amba_addr, data_in;
  logic       read_flag, write_flag;

  apb_reg_bridge #(.DATA_WIDTH(8), .NUM_REGS(NR)) dut (
    .SYS_CLK(SYS_CLK), .rst(rst), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .reg_rdata(reg_rdata),
    .amba_addr(amba_addr), .data_in(data_in), .read_flag(read_flag),
    .write_flag(write_flag)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Register bank environment: writes land on write_flag, reads return
  // data during the strobe cycle, and junk is driven at all other times.
  logic [7:0] bank [NR];
  always @(posedge SYS_CLK) begin
    #1;
    if (write_flag && amba_addr < 8'(NR)) bank[amba_addr[3:0]] = data_in;
    if (read_flag && amba_addr < 8'(NR)) reg_rdata = bank[amba_addr[3:0]];
    else reg_rdata = 8'($urandom);
  end

  // Strobe monitor.
  int wr_cnt = 0, rd_cnt = 0;
  logic [7:0] wr_addr, wr_data, rd_addr;
  always @(negedge SYS_CLK) begin
    if (!rst) begin
      chk("strobe_excl", {31'b0, read_flag & write_flag}, 32'd0);
      if (write_flag) begin wr_cnt++; wr_addr = amba_addr; wr_data = data_in; end
      if (read_flag) begin rd_cnt++; rd_addr = amba_addr; end
    end
  end

  // Reference model: register contents seen at transaction level.
  logic [7:0] ref_mem [NR];

  task automatic model_update(input bit wr, input logic [7:0] addr, input logic [7:0] wdata);
    if (wr && addr < 8'(NR)) ref_mem[addr[3:0]] = wdata;
  endtask

  // One APB transfer, setup phase launched on the next rising edge.
  task automatic xfer(input string tag, input bit wr, input logic [7:0] addr,
                      input logic [7:0] wdata, input int exp_lat,
                      input bit exp_err, input logic [7:0] exp_rd);
    int w0, r0, lat;
    bit ok;
    w0 = wr_cnt; r0 = rd_cnt; lat = 0;
    ok = !exp_err;
    @(posedge SYS_CLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge SYS_CLK); #1;
    PENABLE = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge SYS_CLK);
      if (PREADY) begin lat = c; break; end
    end
    #1;
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_pslverr"}, {31'b0, PSLVERR}, {31'b0, exp_err});
    chk({tag, "_prdata"}, PRDATA, exp_rd);
    chk({tag, "_addr_hold"}, amba_addr, addr);
    chk({tag, "_data_hold"}, data_in, wdata);
    chk({tag, "_wr_strobes"}, wr_cnt - w0, (wr && ok) ? 1 : 0);
    chk({tag, "_rd_strobes"}, rd_cnt - r0, (!wr && ok) ? 1 : 0);
    if (wr && ok) begin
      chk({tag, "_wr_addr"}, wr_addr, addr);
      chk({tag, "_wr_data"}, wr_data, wdata);
    end
    if (!wr && ok) chk({tag, "_rd_addr"}, rd_addr, addr);
    model_update(wr, addr, wdata);
  endtask

  task automatic idle(input int n);
    @(posedge SYS_CLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (n) @(posedge SYS_CLK);
  endtask

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         lat;
    bit         err;
    logic [7:0] rdata;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int w0, r0;
    vecs[0]  = '{1'b1, 8'h03, 8'h5A, WR_LATENCY, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 8'h03, 8'h00, RD_LATENCY, 1'b0, 8'h5A};
    vecs[2]  = '{1'b1, 8'h10, 8'h77, WR_LATENCY, 1'b1, 8'h00};
    vecs[3]  = '{1'b0, 8'h0F, 8'h00, RD_LATENCY, 1'b0, 8'h00};
    vecs[4]  = '{1'b1, 8'h0F, 8'hC3, WR_LATENCY, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 8'h0F, 8'h00, RD_LATENCY, 1'b0, 8'hC3};
    vecs[6]  = '{1'b1, 8'h01, 8'h11, WR_LATENCY, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 8'h01, 8'h00, RD_LATENCY, 1'b0, 8'h11};
    vecs[8]  = '{1'b0, 8'h10, 8'h00, WR_LATENCY, 1'b1, 8'h00};
    vecs[9]  = '{1'b0, 8'hFF, 8'h00, WR_LATENCY, 1'b1, 8'h00};
    vecs[10] = '{1'b1, 8'hFF, 8'hAA, WR_LATENCY, 1'b1, 8'h00};
    vecs[11] = '{1'b0, 8'h03, 8'h00, RD_LATENCY, 1'b0, 8'h5A};

    for (int i = 0; i < int'(NR); i++) begin bank[i] = 8'h00; ref_mem[i] = 8'h00; end
    rst = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 8'h00; PWDATA = 8'h00; reg_rdata = 8'h00;

    // Reset state.
    repeat (3) @(posedge SYS_CLK);
    @(negedge SYS_CLK);
    chk("rst_prdata", PRDATA, 0);
    chk("rst_pready", {31'b0, PREADY}, 0);
    chk("rst_pslverr", {31'b0, PSLVERR}, 0);
    chk("rst_amba_addr", amba_addr, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_read_flag", {31'b0, read_flag}, 0);
    chk("rst_write_flag", {31'b0, write_flag}, 0);
    @(posedge SYS_CLK); #1;
    rst = 1'b0;

    // Directed vectors, issued back-to-back.
    for (int i = 0; i < 12; i++)
      xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
           vecs[i].lat, vecs[i].err, vecs[i].rdata);
    idle(2);

    // Reset while the bridge waits on read data.
    @(posedge SYS_CLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h03; PWDATA = 8'h00;
    @(posedge SYS_CLK); #1;
    PENABLE = 1'b1;
    @(posedge SYS_CLK); #1;
    chk("midrd_read_flag", {31'b0, read_flag}, 1);
    rst = 1'b1;
    @(posedge SYS_CLK); #1;
    rst = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    chk("midrd_pready", {31'b0, PREADY}, 0);
    chk("midrd_prdata", PRDATA, 0);
    chk("midrd_flags", {30'b0, read_flag, write_flag}, 0);
    chk("midrd_amba_addr", amba_addr, 0);
    w0 = wr_cnt; r0 = rd_cnt;
    repeat (2) @(negedge SYS_CLK);
    chk("midrd_no_strobe", (wr_cnt - w0) + (rd_cnt - r0), 0);
    xfer("post_rst_wr", 1'b1, 8'h05, 8'h66, WR_LATENCY, 1'b0, 8'h00);
    idle(1);

    // PSEL dropped in ISSUE, then a stray PENABLE with no setup phase.
    w0 = wr_cnt; r0 = rd_cnt;
    @(posedge SYS_CLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h02; PWDATA = 8'h99;
    @(posedge SYS_CLK); #1;
    PSEL = 1'b0;
    repeat (3) begin
      @(negedge SYS_CLK);
      chk("abort_pready", {31'b0, PREADY}, 0);
    end
    @(posedge SYS_CLK); #1;
    PSEL = 1'b1; PENABLE = 1'b1;
    repeat (2) begin
      @(negedge SYS_CLK);
      chk("stray_pready", {31'b0, PREADY}, 0);
    end
    #1;
    chk("abort_wr_strobes", wr_cnt - w0, 0);
    chk("abort_rd_strobes", rd_cnt - r0, 0);
    xfer("post_abort_rd", 1'b0, 8'h02, 8'h00, RD_LATENCY, 1'b0, ref_mem[2]);

    // Randomised transfers against the register-content model.
    for (int i = 0; i < 200; i++) begin
      bit         wr, err;
      logic [7:0] addr, wdata, exp_rd;
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) addr = 8'($urandom);
      else addr = 8'($urandom_range(0, NR + 3));
      wdata = 8'($urandom);
      err = (addr >= 8'(NR));
      exp_rd = (!wr && !err) ? ref_mem[addr[3:0]] : 8'h00;
      xfer($sformatf("rnd%0d", i), wr, addr, wdata,
           (err || wr) ? WR_LATENCY : RD_LATENCY, err, exp_rd);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 2));
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
